// File: rtl/sub32_serial_pkg.sv
// Shared types and constants for the digit-serial subtractor.
// Holds the FSM state enum, default geometry and the step-counter width helper.
package sub32_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DIGIT = 1;

    // A single-step configuration still needs a 1-bit counter to stay legal.
    function automatic int cnt_width(input int width, input int digit);
        int steps_bits;
        steps_bits = $clog2(width / digit);
        return (steps_bits < 1) ? 1 : steps_bits;
    endfunction

endpackage

// File: rtl/sub32_serial_fa.sv
// One-bit full adder cell; the serial subtractor chains DIGIT of these per cycle.
module fa (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/sub32_serial.sv
// Digit-serial subtractor: a - b - bin evaluated as a + ~b + ~bin, DIGIT bits per
// cycle, with valid/ready handshakes on the operand and result sides.
module sub32_serial
    import sub32_serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = cnt_width(WIDTH, DIGIT);

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("sub32_serial: DIGIT must divide WIDTH");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   nb_q, nb_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               carry_q, carry_d;
    logic               bout_q, bout_d;
    logic               ovf_q, ovf_d;

    logic [DIGIT:0]     chain_c;
    logic [DIGIT-1:0]   sum_digit;
    logic [WIDTH-1:0]   acc_shift;
    logic               last_step;

    assign chain_c[0] = carry_q;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        fa u_fa (
            .a_i  (a_q[i]),
            .b_i  (nb_q[i]),
            .ci_i (chain_c[i]),
            .s_o  (sum_digit[i]),
            .co_o (chain_c[i+1])
        );
    end

    // Sum digits enter at the top, so after N steps the LSB digit has reached bit 0.
    assign acc_shift = (acc_q >> DIGIT) | (WIDTH'(sum_digit) << (WIDTH - DIGIT));
    assign last_step = (cnt_q == CNT_W'(N - 1));

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        nb_d    = nb_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    a_d     = a;
                    nb_d    = ~b;
                    carry_d = ~bin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> DIGIT;
                nb_d    = nb_q >> DIGIT;
                acc_d   = acc_shift;
                carry_d = chain_c[DIGIT];
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_step) begin
                    // Borrow is the inverted carry; overflow compares carries around the MSB.
                    diff_d  = acc_shift;
                    bout_d  = ~chain_c[DIGIT];
                    ovf_d   = chain_c[DIGIT-1] ^ chain_c[DIGIT];
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            nb_q    <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            nb_q    <= nb_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign start_ready = (state_q == ST_IDLE);
    assign res_valid   = (state_q == ST_DONE);
    assign diff        = diff_q;
    assign bout        = bout_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_sub32_serial.sv
// Scoreboard bench for sub32_serial: a DIGIT=1 instance for directed and boundary cases,
// a DIGIT=4 instance for 1000 random vectors against an arithmetic reference model.
module tb_sub32_serial;

    typedef struct {
        logic [31:0] diff;
        logic        bout;
        logic        ovf;
        int          t_acc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        sv    [2];
    logic        sr    [2];
    logic [31:0] a_s   [2];
    logic [31:0] b_s   [2];
    logic        bin_s [2];
    logic        rv    [2];
    logic        rr    [2];
    logic [31:0] d_s   [2];
    logic        bo_s  [2];
    logic        ov_s  [2];

    int          mode  [2];
    logic        rnd   [2];
    logic        taken [2];
    logic [31:0] held_d[2];
    logic        held_b[2];
    logic        held_o[2];
    int          nsteps[2];

    exp_t        q0[$];
    exp_t        q1[$];

    int          cyc;
    int          n_checks;
    int          n_pass;

    sub32_serial #(.WIDTH(32), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .start_valid(sv[0]), .start_ready(sr[0]),
        .a(a_s[0]), .b(b_s[0]), .bin(bin_s[0]),
        .res_valid(rv[0]), .res_ready(rr[0]),
        .diff(d_s[0]), .bout(bo_s[0]), .ovf(ov_s[0])
    );

    sub32_serial #(.WIDTH(32), .DIGIT(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .start_valid(sv[1]), .start_ready(sr[1]),
        .a(a_s[1]), .b(b_s[1]), .bin(bin_s[1]),
        .res_valid(rv[1]), .res_ready(rr[1]),
        .diff(d_s[1]), .bout(bo_s[1]), .ovf(ov_s[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer: mode 0 always ready, 1 stalled, 2 random.
    always @(negedge clk) begin
        rnd[0] = 1'($urandom);
        rnd[1] = 1'($urandom);
    end
    assign rr[0] = (mode[0] == 0) || (mode[0] == 2 && rnd[0]);
    assign rr[1] = (mode[1] == 0) || (mode[1] == 2 && rnd[1]);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Reference: plain integer subtraction, unsigned for borrow, signed for overflow.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic bin);
        exp_t   e;
        longint ud;
        longint sd;
        ud = longint'({32'd0, a}) - longint'({32'd0, b}) - longint'({63'd0, bin});
        sd = longint'($signed(a)) - longint'($signed(b)) - longint'({63'd0, bin});
        e.diff  = ud[31:0];
        e.bout  = (ud < 0);
        e.ovf   = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        e.t_acc = 0;
        return e;
    endfunction

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom % 8)
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic issue(input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic bin, output int waited);
        exp_t e;
        waited   = 0;
        a_s[k]   = a;
        b_s[k]   = b;
        bin_s[k] = bin;
        sv[k]    = 1'b1;
        while (!sr[k] && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!sr[k]) begin
            fail_now("accept_timeout");
            sv[k] = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        e       = model(a, b, bin);
        e.t_acc = cyc;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
        sv[k]  = 1'b0;
        a_s[k] = $urandom;
        b_s[k] = $urandom;
    endtask

    task automatic issue_nw(input int k, input logic [31:0] a, input logic [31:0] b, input logic bin);
        int w;
        issue(k, a, b, bin, w);
    endtask

    task automatic wait_drain(input int k);
        int n;
        n = 0;
        while ((qsize(k) > 0 || rv[k]) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (qsize(k) > 0 || rv[k]) fail_now("drain_timeout");
    endtask

    task automatic mon(input int k);
        exp_t e;
        if (rst || !rv[k]) begin
            taken[k] = 1'b0;
        end else if (!taken[k]) begin
            if (qsize(k) == 0) begin
                check("spurious_valid", 32'd1, 32'd0);
            end else begin
                if (k == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                check("diff",    d_s[k],          e.diff);
                check("bout",    32'(bo_s[k]),    32'(e.bout));
                check("ovf",     32'(ov_s[k]),    32'(e.ovf));
                check("latency", 32'(cyc - e.t_acc), 32'(nsteps[k]));
            end
            taken[k]  = 1'b1;
            held_d[k] = d_s[k];
            held_b[k] = bo_s[k];
            held_o[k] = ov_s[k];
        end else begin
            check("hold_diff", d_s[k],        held_d[k]);
            check("hold_bout", 32'(bo_s[k]),  32'(held_b[k]));
            check("hold_ovf",  32'(ov_s[k]),  32'(held_o[k]));
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic check_idle_zero(input int k, input string tag);
        check({tag, "_start_ready"}, 32'(sr[k]), 32'd1);
        check({tag, "_res_valid"},   32'(rv[k]), 32'd0);
        check({tag, "_diff"},        d_s[k],     32'd0);
        check({tag, "_bout"},        32'(bo_s[k]), 32'd0);
        check({tag, "_ovf"},         32'(ov_s[k]), 32'd0);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w;
        int n;
        cyc      = 0;
        n_checks = 0;
        n_pass   = 0;
        nsteps[0] = 32;
        nsteps[1] = 8;
        for (int k = 0; k < 2; k++) begin
            sv[k]    = 1'b0;
            a_s[k]   = '0;
            b_s[k]   = '0;
            bin_s[k] = 1'b0;
            mode[k]  = 0;
            taken[k] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_idle_zero(0, "reset");
        check_idle_zero(1, "reset4");

        // Directed boundary cases on the bit-serial instance.
        issue_nw(0, 32'd5,          32'd3,          1'b0);
        issue_nw(0, 32'd0,          32'd1,          1'b0);
        issue_nw(0, 32'h8000_0000,  32'd1,          1'b0);
        issue_nw(0, 32'h7FFF_FFFF,  32'hFFFF_FFFF,  1'b1);
        issue_nw(0, 32'h1234_5678,  32'h1234_5678,  1'b1);
        wait_drain(0);

        // Backpressure: result stalled while new operands are offered.
        mode[0] = 1;
        issue_nw(0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
        n = 0;
        while (!rv[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rv[0]) fail_now("bp_valid_timeout");
        a_s[0]   = 32'h0000_1000;
        b_s[0]   = 32'h0000_2000;
        bin_s[0] = 1'b1;
        sv[0]    = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("bp_start_ready", 32'(sr[0]), 32'd0);
            check("bp_res_valid",   32'(rv[0]), 32'd1);
        end
        mode[0] = 0;
        @(negedge clk);
        check("bp_release_ready", 32'(sr[0]), 32'd1);
        check("bp_release_valid", 32'(rv[0]), 32'd0);
        issue(0, 32'h0000_1000, 32'h0000_2000, 1'b1, w);
        check("bp_accept_wait", 32'(w), 32'd0);
        wait_drain(0);

        // Reset at RUN step 10 discards the operation in flight.
        issue_nw(0, 32'hCAFE_0000, 32'h0000_BABE, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q0.delete();
        check_idle_zero(0, "midrun_rst");
        repeat (40) @(negedge clk);
        check("no_stale_valid", 32'(rv[0]), 32'd0);
        issue_nw(0, 32'd100, 32'd1, 1'b0);
        wait_drain(0);

        // Random traffic with a random consumer on the bit-serial instance.
        mode[0] = 2;
        for (int i = 0; i < 30; i++) begin
            issue_nw(0, rnd_op(), rnd_op(), 1'($urandom));
        end
        wait_drain(0);

        // 1000 random vectors on the 4-bit-digit instance.
        mode[1] = 2;
        for (int i = 0; i < 1000; i++) begin
            issue_nw(1, rnd_op(), rnd_op(), 1'($urandom));
        end
        wait_drain(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sub32_serial.md
# sub32_serial

Multi-cycle digit-serial subtractor: computes `a - b - bin` over `WIDTH/DIGIT` clock cycles using a chain of `DIGIT` existing `fa` cells with inverted `b` and inverted borrow. It is the sequential, area-lean counterpart to the combinational ripple adder and sits in datapaths where a 32-bit subtract can tolerate latency. Operands enter and results leave through independent valid/ready handshakes.

## Interface
- `WIDTH`, 32, operand and result width in bits.
- `DIGIT`, 1, bits processed per cycle; must divide `WIDTH` (1, 2, 4, 8).
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_valid`  in  1  operands present.
- `start_ready`  out  1  block can accept operands (high only in IDLE).
- `a`  in  WIDTH  minuend.
- `b`  in  WIDTH  subtrahend.
- `bin`  in  1  borrow in.
- `res_valid`  out  1  result present.
- `res_ready`  in  1  consumer takes result.
- `diff`  out  WIDTH  `(a - b - bin) mod 2^WIDTH`.
- `bout`  out  1  unsigned borrow out: 1 iff `a < b + bin`.
- `ovf`  out  1  two's-complement overflow of the signed subtract.

## Operation
- Arithmetic: `a + ~b + ~bin` through the `fa` chain; carry register initialized to `~bin`; `bout = ~carry_out`; `ovf = carry_into_msb ^ carry_out`.
- FSM states: IDLE, RUN, DONE.
- IDLE: `start_ready=1`. On `start_valid & start_ready`, capture `a`, `~b`, and carry `~bin`; clear the step counter; go to RUN. Operands need not stay stable after acceptance.
- RUN: each cycle, feed the low `DIGIT` bits of the a/b shift registers and the carry register into the `fa` chain. Shift the sum digit into the top of the result register, shift a/b right by `DIGIT`, and update the carry. Record the carry into the MSB on the final step. After `N = WIDTH/DIGIT` steps, go to DONE.
- DONE: `res_valid=1`; `diff`, `bout`, and `ovf` are held stable. On `res_valid & res_ready`, go to IDLE.
- `start_valid` is ignored outside IDLE. `res_ready` is ignored outside DONE.
- Reset, including mid-RUN or mid-DONE: state goes to IDLE, the operation in flight is discarded, and no `res_valid` is produced for it.

## Timing
- Reset values: `start_ready=1` (IDLE), `res_valid=0`, `diff=0`, `bout=0`, `ovf=0`.
- Latency: if operands are accepted on edge T, `res_valid` is high from the cycle after edge T+N (N=32 at defaults).
- Earliest result handshake is edge T+N+1. IDLE is re-entered after it, and the next accept is at edge T+N+2 or later. Throughput is one op per N+2 cycles minimum.
- There is no same-cycle result-out/operand-in overlap.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Result outputs keep their last values in IDLE and RUN; they are meaningful only while `res_valid` is high.

## Structure
- Shared package: FSM state enum (IDLE/RUN/DONE), default `WIDTH`/`DIGIT` constants, and a counter-width function `$clog2(WIDTH/DIGIT)`.
- Sub-module: the existing `fa` 1-bit full adder, with `DIGIT` instances chained in a generate loop.
- Elaboration-time check that `WIDTH % DIGIT == 0`.

## Test plan
- `a=5, b=3, bin=0`: `diff=2`, `bout=0`, `ovf=0`. `res_valid` rises exactly 32 edges after accept.
- `a=0, b=1, bin=0`: `diff=0xFFFFFFFF`, `bout=1`, `ovf=0`. Also `a=0x80000000, b=1`: `diff=0x7FFFFFFF`, `bout=0`, `ovf=1`.
- `a=0x7FFFFFFF, b=0xFFFFFFFF, bin=1`: `diff=0x7FFFFFFF`, `bout=1`, `ovf=0`. Also `a=b=0x12345678, bin=1`: `diff=0xFFFFFFFF`, `bout=1`.
- Backpressure: hold `res_ready=0` for 10 cycles while driving `start_valid=1` with new operands. Required: result held constant, `start_ready=0`, no capture. Release: handshake, then the new operands are accepted 1 cycle later and give a correct result.
- Assert `rst` during RUN step 10. Required: IDLE next cycle, `start_ready=1`, all outputs 0, no stale `res_valid`. A following `100-1` gives `99`.
- `DIGIT=4`: a random set of 1000 vectors matches the reference model, with latency exactly 8 edges.
